// File: rtl/fft_ifft_pkg.sv
// Shared types and helpers for the IFFT frame reader: FSM states, register map, status bits,
// and the round-then-saturate scaler applied to each captured sample.
package fft_ifft_pkg;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    FILL      = 1'b1
  } wstate_e;

  localparam logic STATUS   = 1'b0;
  localparam logic FRAMECNT = 1'b1;

  localparam int ST_READY   = 0;
  localparam int ST_FILL    = 1;
  localparam int ST_OVR_LSB = 8;

  // Round half up, arithmetic shift, then clamp to a signed owidth-bit range.
  // 64-bit working width holds any IWIDTH+1 intermediate exactly.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] re,
                                                   input int shift,
                                                   input int owidth);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (re + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (owidth - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (owidth - 1));
    if (r > hi)      sat_round = hi;
    else if (r < lo) sat_round = lo;
    else             sat_round = r;
  endfunction

endpackage

// File: rtl/frame_buf_ram.sv
// Simple dual-port frame buffer: one synchronous write port, one registered read port.
// Read data appears the cycle after re_i and holds while re_i is low.
module frame_buf_ram #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ifft_frame_reader.sv
// Captures sync-delimited IFFT frames into a ping-pong buffer and serves them to the host.
// Host reads return one cycle after read; a frame arriving while the host holds the other is dropped.
module ifft_frame_reader
  import fft_ifft_pkg::*;
#(
  parameter int IWIDTH  = 26,
  parameter int OWIDTH  = 16,
  parameter int LGWIDTH = 9,
  parameter int SHIFT   = 10
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_ce,
  input  logic [2*IWIDTH-1:0]   i_result,
  input  logic                  i_sync,
  input  logic [LGWIDTH:0]      address,
  input  logic                  read,
  input  logic                  write,
  input  logic [OWIDTH-1:0]     writedata,
  output logic [OWIDTH-1:0]     readdata,
  output logic                  o_irq
);

  localparam int CW = OWIDTH - ST_OVR_LSB;

  wstate_e              state_q;
  logic [LGWIDTH-1:0]   idx_q;
  logic                 wbank_q;
  logic                 ready_q;
  logic [CW-1:0]        ovr_cnt_q;
  logic [OWIDTH-1:0]    frame_cnt_q;
  logic                 irq_q;
  logic                 rsel_q;
  logic [OWIDTH-1:0]    rreg_q;

  logic                 we;
  logic [LGWIDTH-1:0]   widx;
  logic [LGWIDTH-1:0]   idx_d;
  logic                 complete;
  logic                 reg_sel;
  logic                 reg_idx;
  logic                 release_w;
  logic                 ovr_clr;
  logic                 swap;
  logic                 overrun;
  logic signed [63:0]   re_ext;
  logic signed [63:0]   scaled;
  logic [OWIDTH-1:0]    status_w;
  logic [OWIDTH-1:0]    ram_rdata;
  logic                 unused_bits;

  // A sync sample always lands at index 0, whether starting or resyncing.
  assign we        = i_ce && (i_sync || state_q == FILL);
  assign widx      = i_sync ? '0 : idx_q;
  assign idx_d     = widx + 1'b1;
  assign complete  = we && (widx == '1);

  assign reg_sel   = address[LGWIDTH];
  assign reg_idx   = address[0];
  assign release_w = write && reg_sel && (reg_idx == STATUS) && writedata[0];
  assign ovr_clr   = write && reg_sel && (reg_idx == STATUS) && writedata[1];

  assign swap      = complete && (!ready_q || release_w);
  assign overrun   = complete && ready_q && !release_w;

  assign re_ext    = 64'(signed'(i_result[2*IWIDTH-1:IWIDTH]));
  assign scaled    = sat_round(re_ext, SHIFT, OWIDTH);

  always_comb begin
    status_w                        = '0;
    status_w[ST_READY]              = ready_q;
    status_w[ST_FILL]               = (state_q == FILL);
    status_w[OWIDTH-1:ST_OVR_LSB]   = ovr_cnt_q;
  end

  frame_buf_ram #(
    .AW (LGWIDTH + 1),
    .DW (OWIDTH)
  ) u_ram (
    .clk_i   (i_clk),
    .we_i    (we),
    .waddr_i ({wbank_q, widx}),
    .wdata_i (scaled[OWIDTH-1:0]),
    .re_i    (read && !reg_sel),
    .raddr_i ({~wbank_q, address[LGWIDTH-1:0]}),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= WAIT_SYNC;
      idx_q       <= '0;
      wbank_q     <= 1'b0;
      ready_q     <= 1'b0;
      ovr_cnt_q   <= '0;
      frame_cnt_q <= '0;
      irq_q       <= 1'b0;
      rsel_q      <= 1'b1;
      rreg_q      <= '0;
    end else begin
      irq_q <= swap;

      if (we) begin
        if (complete) begin
          state_q <= WAIT_SYNC;
          idx_q   <= '0;
        end else begin
          state_q <= FILL;
          idx_q   <= idx_d;
        end
      end

      if (swap) begin
        wbank_q     <= ~wbank_q;
        ready_q     <= 1'b1;
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end else if (release_w) begin
        ready_q <= 1'b0;
      end

      if (ovr_clr)                          ovr_cnt_q <= '0;
      else if (overrun && ovr_cnt_q != '1)  ovr_cnt_q <= ovr_cnt_q + 1'b1;

      // Register reads capture pre-update state, so a same-cycle release reads as still ready.
      if (read) begin
        rsel_q <= reg_sel;
        if (reg_sel) rreg_q <= (reg_idx == FRAMECNT) ? frame_cnt_q : status_w;
      end
    end
  end

  assign readdata = rsel_q ? rreg_q : ram_rdata;
  assign o_irq    = irq_q;

  assign unused_bits = ^{scaled[63:OWIDTH], i_result[IWIDTH-1:0], writedata[OWIDTH-1:2]};

endmodule

// File: tb/tb_ifft_frame_reader.sv
// Scoreboarded bench for ifft_frame_reader: directed frames, host reads checked by a monitor.
module tb_ifft_frame_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_ce = 1'b0;
  logic [51:0] i_result = '0;
  logic        i_sync = 1'b0;
  logic [9:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic        o_irq;

  localparam logic [9:0] A_STAT = 10'h200;
  localparam logic [9:0] A_FCNT = 10'h201;

  int          checks = 0;
  int          errors = 0;
  int          irq_cnt = 0;
  logic [15:0] sb[$];

  ifft_frame_reader dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_ce      (i_ce),
    .i_result  (i_result),
    .i_sync    (i_sync),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .o_irq     (o_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  // Read monitor: a read seen at a rising edge is compared at the following falling edge.
  initial begin
    logic p;
    forever begin
      @(posedge clk);
      p = read;
      @(negedge clk);
      if (o_irq) irq_cnt++;
      if (p) begin
        if (sb.size() == 0) check("rd_unexpected", readdata, 16'hxxxx);
        else check("rd", readdata, sb.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic signed [25:0] re, input logic sync);
    @(negedge clk);
    i_ce     = 1'b1;
    i_sync   = sync;
    i_result = {re, 26'h0155};
  endtask

  task automatic ce_off();
    @(negedge clk);
    i_ce   = 1'b0;
    i_sync = 1'b0;
    write  = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, input logic [15:0] exp);
    @(negedge clk);
    read    = 1'b1;
    address = a;
    sb.push_back(exp);
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic wr(input logic [9:0] a, input logic [15:0] d);
    @(negedge clk);
    write     = 1'b1;
    address   = a;
    writedata = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  function automatic logic signed [25:0] re_of(input int mode, input int k);
    case (mode)
      1: begin
        case (k)
          0: return 26'sd33554431;
          1: return -26'sd33554432;
          2: return 26'sd1535;
          3: return -26'sd512;
          default: return 26'(k * 1024);
        endcase
      end
      2: return 26'((k + 7) * 1024);
      3: return 26'(k * 2048);
      default: return 26'(k * 1024);
    endcase
  endfunction

  task automatic send_frame(input int mode, input bit rel_at_end);
    for (int k = 0; k < 512; k++) begin
      send(re_of(mode, k), k == 0);
      if (rel_at_end && k == 511) begin
        write     = 1'b1;
        address   = A_STAT;
        writedata = 16'h0001;
      end
    end
    ce_off();
    idle(3);
  endtask

  initial begin
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);
    check("reset_readdata", readdata, 16'h0000);
    check("reset_irq", 16'(o_irq), 16'h0000);
    rd(A_STAT, 16'h0000);
    rd(A_FCNT, 16'h0000);

    // Frame 1: re(k) = k*1024, stored value k.
    send_frame(0, 1'b0);
    check("irq_frame1", 16'(irq_cnt), 16'd1);
    rd(A_STAT, 16'h0001);
    rd(10'd0, 16'd0);
    rd(10'd1, 16'd1);
    rd(10'd255, 16'd255);
    rd(10'd511, 16'd511);
    rd(A_FCNT, 16'd1);
    idle(3);
    check("readdata_hold", readdata, 16'd1);

    // Host writes to sample space and frame count are ignored.
    wr(10'd5, 16'hBEEF);
    wr(A_FCNT, 16'h0042);
    rd(10'd5, 16'd5);
    rd(A_FCNT, 16'd1);

    // Frame 2 with no release: dropped, overrun counted.
    send_frame(1, 1'b0);
    check("irq_overrun", 16'(irq_cnt), 16'd1);
    rd(A_STAT, 16'h0101);
    rd(10'd0, 16'd0);
    rd(10'd511, 16'd511);
    wr(A_STAT, 16'h0002);
    rd(A_STAT, 16'h0001);

    // Frame 3 with release on the completing cycle: scaling vectors in front.
    send_frame(1, 1'b1);
    check("irq_rel_same", 16'(irq_cnt), 16'd2);
    rd(A_STAT, 16'h0001);
    rd(A_FCNT, 16'd2);
    rd(10'd0, 16'h7FFF);
    rd(10'd1, 16'h8000);
    rd(10'd2, 16'h0001);
    rd(10'd3, 16'h0000);
    rd(10'd4, 16'd4);

    // Resync at index 200: only the post-resync frame survives.
    wr(A_STAT, 16'h0001);
    rd(A_STAT, 16'h0000);
    for (int k = 0; k < 200; k++) send(26'sd102400, k == 0);
    send_frame(2, 1'b0);
    check("irq_resync", 16'(irq_cnt), 16'd3);
    rd(10'd0, 16'd7);
    rd(10'd199, 16'd206);
    rd(10'd511, 16'd518);
    rd(A_FCNT, 16'd3);

    // Reset in the middle of a fill, then samples with no sync.
    wr(A_STAT, 16'h0001);
    for (int k = 0; k < 100; k++) send(26'(k * 1024), k == 0);
    rd(A_STAT, 16'h0002);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 512; k++) send(26'(k * 1024), 1'b0);
    ce_off();
    idle(3);
    check("irq_after_rst", 16'(irq_cnt), 16'd3);
    rd(A_STAT, 16'h0000);
    rd(A_FCNT, 16'h0000);
    send_frame(3, 1'b0);
    check("irq_post_rst", 16'(irq_cnt), 16'd4);
    rd(A_STAT, 16'h0001);
    rd(A_FCNT, 16'd1);
    rd(10'd10, 16'd20);

    idle(3);
    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
